// File: rtl/cp0_intctl.sv
// Coprocessor-0 exception/interrupt controller: synchronizes irq, captures EPC/Cause on
// trap or enabled interrupt, redirects to VECTOR for one cycle, and returns on ERET.
module cp0_intctl #(
    parameter int              wide   = 32,
    parameter logic [wide-1:0] VECTOR = 32'h0000_0080,
    parameter int              NIRQ   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            trap,
    input  logic [wide-1:0] pc,
    input  logic            eret,
    input  logic            we_cp0,
    input  logic [4:0]      cp0_addr,
    input  logic [wide-1:0] cp0_wd,
    output logic [wide-1:0] cp0_rd,
    output logic            exl,
    output logic            iv,
    output logic [wide-1:0] vec_pc,
    output logic [wide-1:0] epc
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_HANDLER  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [NIRQ-1:0] sync1_q, sync1_d, ip_q, ip_d;
    logic            ie_q, ie_d;
    logic [NIRQ-1:0] im_q, im_d;
    logic            df_q, df_d;
    logic [4:0]      exc_q, exc_d;
    logic [wide-1:0] epc_q, epc_d;
    logic            exl_q, exl_d;
    logic            iv_q, iv_d;
    logic            take;
    logic            wr_status, wr_cause, wr_epc;

    assign wr_status = we_cp0 && (cp0_addr == 5'd12);
    assign wr_cause  = we_cp0 && (cp0_addr == 5'd13);
    assign wr_epc    = we_cp0 && (cp0_addr == 5'd14);
    assign take      = (state_q == ST_RUN) && (trap || (ie_q && |(ip_q & im_q)));

    always_comb begin
        sync1_d = irq;
        ip_d    = sync1_q;
        state_d = state_q;
        ie_d    = ie_q;
        im_d    = im_q;
        df_d    = df_q;
        exc_d   = exc_q;
        epc_d   = epc_q;

        if (wr_status) begin
            ie_d = cp0_wd[0];
            im_d = cp0_wd[NIRQ+7:8];
        end
        if (wr_cause && !cp0_wd[31]) df_d = 1'b0;
        // A nested trap cannot be serviced; it only leaves a sticky marker.
        if ((state_q == ST_HANDLER) && trap) df_d = 1'b1;
        if (wr_epc && (state_q != ST_REDIRECT)) epc_d = cp0_wd;
        // Hardware capture overrides a same-cycle MTC0 to EPC.
        if (take) begin
            epc_d = pc;
            exc_d = trap ? 5'd13 : 5'd0;
        end

        case (state_q)
            ST_RUN:      if (take) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_HANDLER;
            ST_HANDLER:  if (eret) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        exl_d = (state_d != ST_RUN);
        iv_d  = (state_d == ST_REDIRECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            sync1_q <= '0;
            ip_q    <= '0;
            ie_q    <= 1'b0;
            im_q    <= '0;
            df_q    <= 1'b0;
            exc_q   <= '0;
            epc_q   <= '0;
            exl_q   <= 1'b0;
            iv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            ip_q    <= ip_d;
            ie_q    <= ie_d;
            im_q    <= im_d;
            df_q    <= df_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
            exl_q   <= exl_d;
            iv_q    <= iv_d;
        end
    end

    always_comb begin
        cp0_rd = '0;
        case (cp0_addr)
            5'd12: begin
                cp0_rd[0]         = ie_q;
                cp0_rd[1]         = exl_q;
                cp0_rd[NIRQ+7:8]  = im_q;
            end
            5'd13: begin
                cp0_rd[31]        = df_q;
                cp0_rd[NIRQ+7:8]  = ip_q;
                cp0_rd[6:2]       = exc_q;
            end
            5'd14:   cp0_rd = epc_q;
            default: cp0_rd = '0;
        endcase
    end

    assign exl    = exl_q;
    assign iv     = iv_q;
    assign epc    = epc_q;
    assign vec_pc = VECTOR;

endmodule

// File: tb/tb_cp0_intctl.sv
// Bench for cp0_intctl: a directed vector table, async-reset corner case, and
// randomized traffic checked against a rule-level reference model.
module tb_cp0_intctl;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq;
    logic         trap;
    logic [W-1:0] pc;
    logic         eret;
    logic         we_cp0;
    logic [4:0]   cp0_addr;
    logic [W-1:0] cp0_wd;
    logic [W-1:0] cp0_rd;
    logic         exl;
    logic         iv;
    logic [W-1:0] vec_pc;
    logic [W-1:0] epc;

    cp0_intctl #(.wide(W), .VECTOR(32'h0000_0080), .NIRQ(N)) dut (
        .clk(clk), .rst(rst), .irq(irq), .trap(trap), .pc(pc), .eret(eret),
        .we_cp0(we_cp0), .cp0_addr(cp0_addr), .cp0_wd(cp0_wd), .cp0_rd(cp0_rd),
        .exl(exl), .iv(iv), .vec_pc(vec_pc), .epc(epc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = running, 1 = redirect cycle, 2 = inside handler
    int           m_mode;
    logic         m_ie, m_df;
    logic [N-1:0] m_im;
    logic [4:0]   m_exc;
    logic [W-1:0] m_epc;
    logic [N-1:0] irq_hist[$];   // irq value seen at each clock edge, oldest first

    function automatic logic [N-1:0] m_ip();
        if (irq_hist.size() >= 2) return irq_hist[irq_hist.size()-2];
        return '0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ie = 0; m_df = 0; m_im = '0; m_exc = '0; m_epc = '0;
        irq_hist.delete();
    endtask

    task automatic model_edge();
        bit take;
        take = (m_mode == 0) && (trap || (m_ie && ((m_ip() & m_im) != '0)));
        if (we_cp0 && cp0_addr == 5'd12) begin
            m_ie = cp0_wd[0];
            m_im = cp0_wd[N+7:8];
        end
        if (we_cp0 && cp0_addr == 5'd13 && !cp0_wd[31]) m_df = 0;
        if (m_mode == 2 && trap) m_df = 1;
        if (take) begin
            m_epc = pc;
            m_exc = trap ? 5'd13 : 5'd0;
        end else if (we_cp0 && cp0_addr == 5'd14 && m_mode != 1) begin
            m_epc = cp0_wd;
        end
        case (m_mode)
            0: m_mode = take ? 1 : 0;
            1: m_mode = 2;
            default: m_mode = eret ? 0 : 2;
        endcase
        irq_hist.push_back(irq);
        if (irq_hist.size() > 4) void'(irq_hist.pop_front());
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 5'd12) begin
            r[0] = m_ie;
            r[1] = (m_mode != 0);
            r[N+7:8] = m_im;
        end else if (a == 5'd13) begin
            r[31] = m_df;
            r[N+7:8] = m_ip();
            r[6:2] = m_exc;
        end else if (a == 5'd14) begin
            r = m_epc;
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        irq = '0; trap = 0; pc = '0; eret = 0; we_cp0 = 0; cp0_addr = 5'd0; cp0_wd = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         trap, eret, we;
        logic [4:0]   addr;
        logic [31:0]  wd, pcv;
        logic [N-1:0] irqv;
        logic         x_exl, x_iv;
        logic [31:0]  x_rd;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic t, input logic e, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] p, input logic [N-1:0] q,
                       input logic xe, input logic xi, input logic [31:0] xr);
        vec_t v;
        v.trap = t; v.eret = e; v.we = w; v.addr = a; v.wd = d; v.pcv = p; v.irqv = q;
        v.x_exl = xe; v.x_iv = xi; v.x_rd = xr;
        vt.push_back(v);
    endtask

    initial begin
        rst = 1;
        idle_inputs();

        //    trap eret we addr  wd      pc      irq   exl iv  rd
        add(1, 0, 0, 14, 32'h0,   32'h40,  4'h0, 1, 1, 32'h40);
        add(0, 0, 0, 13, 32'h0,   32'h44,  4'h0, 1, 0, 32'h34);
        add(0, 1, 0, 13, 32'h0,   32'h48,  4'h0, 0, 0, 32'h34);
        add(0, 0, 1, 12, 32'h101, 32'h4c,  4'h0, 0, 0, 32'h101);
        add(0, 0, 0, 12, 32'h0,   32'h100, 4'h1, 0, 0, 32'h101);
        add(0, 0, 0, 13, 32'h0,   32'h104, 4'h1, 0, 0, 32'h134);
        add(0, 0, 0, 14, 32'h0,   32'h108, 4'h1, 1, 1, 32'h108);
        add(0, 0, 0, 13, 32'h0,   32'h10c, 4'h1, 1, 0, 32'h100);
        add(1, 0, 0, 13, 32'h0,   32'h200, 4'h1, 1, 0, 32'h8000_0100);
        add(0, 0, 0, 14, 32'h0,   32'h204, 4'h1, 1, 0, 32'h108);
        add(0, 1, 0, 13, 32'h0,   32'h208, 4'h1, 0, 0, 32'h8000_0100);
        add(0, 0, 0, 14, 32'h0,   32'h300, 4'h1, 1, 1, 32'h300);
        add(0, 0, 1, 13, 32'h0,   32'h304, 4'h1, 1, 0, 32'h100);
        add(0, 1, 0, 12, 32'h0,   32'h308, 4'h1, 0, 0, 32'h101);
        add(1, 0, 0, 13, 32'h0,   32'h400, 4'h1, 1, 1, 32'h134);
        add(0, 0, 0, 13, 32'h0,   32'h404, 4'h1, 1, 0, 32'h134);
        add(0, 0, 1, 14, 32'h500, 32'h408, 4'h1, 1, 0, 32'h500);
        add(0, 1, 1, 12, 32'h100, 32'h40c, 4'h1, 0, 0, 32'h100);
        add(0, 0, 1, 12, 32'h2,   32'h410, 4'h1, 0, 0, 32'h0);
        add(0, 0, 0, 13, 32'h0,   32'h414, 4'h1, 0, 0, 32'h134);
        add(0, 0, 1, 12, 32'h1,   32'h418, 4'h1, 0, 0, 32'h1);
        add(0, 0, 0, 12, 32'h0,   32'h41c, 4'h1, 0, 0, 32'h1);
        add(0, 0, 0, 14, 32'h0,   32'h420, 4'h1, 0, 0, 32'h500);

        // reset state
        do_reset();
        chk("rst_exl", {31'b0, exl}, 32'h0);
        chk("rst_iv", {31'b0, iv}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("vec_pc", vec_pc, 32'h80);
        for (int a = 12; a <= 14; a++) begin
            cp0_addr = 5'(a);
            #1;
            chk($sformatf("rst_rd%0d", a), cp0_rd, 32'h0);
        end

        foreach (vt[i]) begin
            trap = vt[i].trap; eret = vt[i].eret; we_cp0 = vt[i].we;
            cp0_addr = vt[i].addr; cp0_wd = vt[i].wd; pc = vt[i].pcv; irq = vt[i].irqv;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_exl", i), {31'b0, exl}, {31'b0, vt[i].x_exl});
            chk($sformatf("vec%0d_iv", i), {31'b0, iv}, {31'b0, vt[i].x_iv});
            chk($sformatf("vec%0d_rd", i), cp0_rd, vt[i].x_rd);
        end

        // asynchronous reset while in the redirect cycle
        do_reset();
        trap = 1; pc = 32'h40;
        @(posedge clk);
        #1;
        trap = 0;
        chk("redir_iv", {31'b0, iv}, 32'h1);
        #2;
        rst = 1;
        #1;
        chk("arst_exl", {31'b0, exl}, 32'h0);
        chk("arst_iv", {31'b0, iv}, 32'h0);
        chk("arst_epc", epc, 32'h0);
        for (int a = 12; a <= 14; a++) begin
            cp0_addr = 5'(a);
            #1;
            chk($sformatf("arst_rd%0d", a), cp0_rd, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            trap     = ($urandom_range(0, 7) == 0);
            eret     = ($urandom_range(0, 2) == 0);
            we_cp0   = ($urandom_range(0, 2) == 0);
            cp0_addr = 5'($urandom_range(10, 16));
            cp0_wd   = $urandom;
            pc       = $urandom;
            if ($urandom_range(0, 7) == 0) irq = N'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1;
                #1;
                chk("rnd_arst_exl", {31'b0, exl}, 32'h0);
                chk("rnd_arst_epc", epc, 32'h0);
                @(posedge clk);
                #1;
                rst = 0;
                model_reset();
                continue;
            end
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_exl", {31'b0, exl}, {31'b0, (m_mode != 0)});
            chk("rnd_iv", {31'b0, iv}, {31'b0, (m_mode == 1)});
            chk("rnd_epc", epc, m_epc);
            chk($sformatf("rnd_rd%0d", cp0_addr), cp0_rd, exp_rd(cp0_addr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_intctl.md
Name: cp0_intctl

Overview:
Coprocessor-0 exception and interrupt controller for the MIPS core.
- Produces the EXL and IV signals that the main decoder consumes.
- Captures EPC and Cause when the ALU raises a trap or an enabled external interrupt arrives.
- Services MFC0/MTC0 accesses and returns from the handler on ERET.
- Sits beside the regfile; the datapath muxes PC to vec_pc on iv and to epc on eret.

Parameters:
wide, 32, datapath width for pc, epc and CP0 data.
VECTOR, 32'h0000_0080, exception handler entry address driven on vec_pc.
NIRQ, 4, number of external interrupt lines (1..8).

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
irq  in  NIRQ  external interrupt requests; level-sensitive, asynchronous to clk
trap  in  1  trap from the ALU (TNE/TEQ condition true) for the current instruction
pc  in  wide  address of the instruction currently in execute
eret  in  1  current instruction is ERET
we_cp0  in  1  MTC0 write enable (the weCP0 control signal)
cp0_addr  in  5  CP0 register number for MFC0/MTC0
cp0_wd  in  wide  MTC0 write data
cp0_rd  out  wide  MFC0 read data; combinational from cp0_addr
exl  out  1  exception level; high while a handler is active
iv  out  1  one-cycle redirect pulse; the PC loads vec_pc on the next edge
vec_pc  out  wide  constant VECTOR
epc  out  wide  saved return address; the PC loads it when eret is accepted

Behaviour:
- Reset (async): state RUN; Status, Cause, EPC, synchronizer flops all 0; exl=0, iv=0, cp0_rd per addr (0s).
- irq passes a 2-flop synchronizer to form ip[NIRQ-1:0]; 2-cycle latency, no latching (level).
- Register map: 12=Status {IM[15:8], EXL[1], IE[0]}; 13=Cause {DF[31], IP[15:8], ExcCode[6:2]}; 14=EPC; all other addresses read 0.
- Unimplemented Status/Cause bits read 0. IP mirrors ip.
- EXL bit = (state != RUN); it is read-only, so MTC0 writes to it are ignored.
- FSM states:
  - RUN, then REDIRECT on take. Take = trap, or (IE & |(ip & IM[NIRQ+7:8])).
    - On take: EPC<=pc; ExcCode<=13 if trap, else 0; trap has priority over interrupt.
  - REDIRECT: iv=1, exl=1; goes unconditionally to HANDLER next edge.
    - eret, trap and interrupts are ignored in this state.
  - HANDLER: exl=1.
    - eret: go to RUN on the next edge, exl=0 the following cycle.
    - Interrupts stay pending.
    - trap sets the sticky DF bit; no capture, no EPC change.
- exl and iv are registered outputs derived from state (no combinational path from trap/irq).
- An interrupt still asserted after eret is taken in the first RUN cycle (back-to-back allowed).
- eret in RUN is ignored.
- MTC0:
  - Status writes IE and IM.
  - Cause writes clear DF when cp0_wd[31]=0; IP and ExcCode are hardware-owned.
  - EPC is writable only when state != REDIRECT.
- Simultaneous MTC0 and take in RUN: hardware capture wins for EPC/ExcCode; the Status write of IE/IM still applies.
- Reset asserted mid-handler returns to RUN immediately, with EPC/Cause cleared.

Test Plan:
- Reset, then trap=1, pc=32'h40 for one cycle: next cycle iv=1, exl=1; cp0_rd@14=32'h40, ExcCode=13; following cycle iv=0, exl=1.
- Status=32'h0000_0101 (IE, IM0); irq[0] rises: iv pulses exactly 3 cycles after irq (2 sync + 1 take); EPC=pc at the take edge; ExcCode=0.
- In HANDLER, eret=1: exl=0 next cycle; with irq[0] still high, iv rises again 2 cycles after eret.
- trap and irq[0] in the same RUN cycle: ExcCode=13, a single iv pulse. A trap during HANDLER sets DF (Cause=32'h8000_0000 | IP), and EPC is unchanged.
- IE=0 or IM0=0 with irq[0]=1: no iv ever; Cause IP bit 8 reads 1; MTC0 to Status bit 1 leaves exl=0.
- Assert rst in the REDIRECT state: exl=0, iv=0, and Status/Cause/EPC all read 0 immediately (asynchronous).
